// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit, its decoder and the stall logic.
package mdu_pkg;

   // Operation codes carried on the Op field; codes 6 and 7 are reserved.
   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   // Default latencies, in busy cycles.
   localparam int MD_MULT_CYCLES_DEF = 5;
   localparam int MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed from the latched operands and committed to HI/LO
// on the edge where the busy down-counter reaches zero.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [2:0]  Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        Cancel,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   logic [CW-1:0] r_cnt;
   logic [31:0]   r_a;
   logic [31:0]   r_b;
   logic [2:0]    r_op;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;

   logic                w_busy;
   logic                w_accept;
   logic signed [63:0]  w_a_sx;
   logic signed [63:0]  w_b_sx;
   logic [63:0]         w_prod_s;
   logic [63:0]         w_prod_u;
   logic                w_div_ovf;
   logic signed [31:0]  w_div_b;
   logic [31:0]         w_quot_s;
   logic [31:0]         w_rem_s;
   logic [31:0]         w_quot_u;
   logic [31:0]         w_rem_u;

   assign w_busy   = (r_cnt != '0);
   assign w_accept = Start & ~Cancel & ~w_busy;

   // Full-width products from the latched operands.
   assign w_a_sx   = {{32{r_a[31]}}, r_a};
   assign w_b_sx   = {{32{r_b[31]}}, r_b};
   assign w_prod_s = w_a_sx * w_b_sx;
   assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

   // The one overflowing signed divide is handled explicitly; its divisor is
   // replaced so the shared divider never sees the overflowing combination.
   assign w_div_ovf = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
   assign w_div_b   = w_div_ovf ? 32'sd1 : $signed(r_b);
   assign w_quot_s  = w_div_ovf ? 32'h8000_0000 : 32'($signed(r_a) / w_div_b);
   assign w_rem_s   = w_div_ovf ? 32'd0         : 32'($signed(r_a) % w_div_b);
   assign w_quot_u  = r_a / r_b;
   assign w_rem_u   = r_a % r_b;

   // Counter, operand latches and HI/LO: accept, count down, commit at 1->0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_op  <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
      end else if (w_busy) begin
         r_cnt <= r_cnt - CW'(1);
         if (r_cnt == CW'(1)) begin
            case (r_op)
               MD_MULT:  {r_hi, r_lo} <= w_prod_s;
               MD_MULTU: {r_hi, r_lo} <= w_prod_u;
               MD_DIV: begin
                  if (r_b != 32'd0) begin
                     r_lo <= w_quot_s;
                     r_hi <= w_rem_s;
                  end
               end
               MD_DIVU: begin
                  if (r_b != 32'd0) begin
                     r_lo <= w_quot_u;
                     r_hi <= w_rem_u;
                  end
               end
               default: ;
            endcase
         end
      end else if (w_accept) begin
         case (Op)
            MD_MULT, MD_MULTU: begin
               r_a   <= A;
               r_b   <= B;
               r_op  <= Op;
               r_cnt <= CW'(MULT_CYCLES);
            end
            MD_DIV, MD_DIVU: begin
               r_a   <= A;
               r_b   <= B;
               r_op  <= Op;
               r_cnt <= CW'(DIV_CYCLES);
            end
            MD_MTHI: r_hi <= A;
            MD_MTLO: r_lo <= A;
            default: ;
         endcase
      end
   end

   assign Busy = w_busy;
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule
